uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BITS, default 8: UART frame data width.
REQ-002 Parameter N, default 4: number of requesters, 2..8; GW = clog2(N).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N  per-requester byte available; held, with data and last stable, until that requester's ready pulse.
REQ-006 req_data  input  N*BITS  requester i's byte in bits [i*BITS +: BITS].
REQ-007 req_last  input  N  marks the final byte of the requester's packet.
REQ-008 req_ready  output  N  registered, one-hot, 1-cycle pulse when that requester's byte is accepted.
REQ-009 tx_start  output  1  registered, 1-cycle pulse that starts the shared transmitter.
REQ-010 tx_data  output  BITS  registered byte for the transmitter; held until the next issue.
REQ-011 tx_busy  input  1  high while the transmitter is shifting a frame.
REQ-012 grant_id  output  GW  index of the current or last granted requester.
REQ-013 locked  output  1  high while a multi-byte packet holds the grant.

Function
REQ-014 The FSM SHALL have states IDLE, LOCKED, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE:
- With any req_valid high, select a winner by round-robin from ptr.
- Next edge: grant_id<=winner; tx_data<=its byte; tx_start<=1; req_ready[winner]<=1; locked<=!req_last[winner]; go to WAIT_BUSY.
REQ-016 Round-robin order SHALL be ptr, ptr+1, ... modulo N, with wrap-around from N-1 to 0.
REQ-017 ptr SHALL become grant_id+1 (mod N) only when a byte with req_last=1 is accepted.
REQ-018 LOCKED:
- Only req_valid[grant_id] is considered; all other requests are ignored.
- On req_valid[grant_id], issue exactly as in REQ-015 with the same grant_id.
- With no valid from the granted requester, stay in LOCKED indefinitely; there is no timeout.
REQ-019 WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
REQ-020 WAIT_DONE: wait for tx_busy=0, then go to LOCKED if locked=1, else IDLE.
REQ-021 tx_start and req_ready SHALL be high for exactly one cycle per issue and SHALL be low in every other cycle.
REQ-022 Latency: req_valid sampled in IDLE/LOCKED gives tx_start and req_ready in the next cycle.
REQ-023 Simultaneous valids SHALL yield exactly one grant, the first in round-robin order.
REQ-024 req_valid changes in WAIT_BUSY/WAIT_DONE SHALL have no effect.
REQ-025 Minimum issue-to-issue spacing SHALL be 4 cycles.

Reset
REQ-026 On rst=1 at a clock edge, all state and outputs SHALL reset:
- state=IDLE, ptr=0, grant_id=0, locked=0, tx_start=0, req_ready=0, tx_data=0.
REQ-027 Reset mid-frame or mid-packet SHALL abandon the packet and the lock; requesters re-arbitrate from ptr=0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the arbiter state enum and the default BITS constant.
REQ-029 One sub-module, rr_arbiter (combinational: valid vector + ptr -> one-hot winner + index, any_valid), SHALL be instantiated once.
REQ-030 The transmitter SHALL remain a separate module connected through tx_start, tx_data and tx_busy.

Verification
REQ-031 Transmitter model asserts tx_busy the cycle after tx_start, for 16 cycles.
REQ-032 Single requester: req_valid=0001, data0=8'h5C, last=1.
- tx_start one cycle later, tx_data=8'h5C, req_ready=0001.
- After busy falls: IDLE, ptr=1.
REQ-033 All four requesters valid, each sending a last byte 8'hA0+i.
- Grants 0,1,2,3 in order; tx_data A0,A1,A2,A3; ptr wraps to 0.
REQ-034 Requester 2 sends a 3-byte packet (last=0,0,1) while requester 1 is continuously valid.
- Bytes of 2 go back-to-back; locked=1 until the third byte; then requester 1 is granted.
REQ-035 Locked requester drops valid for 50 cycles.
- Arbiter stays in LOCKED; no tx_start; resumes on the next valid.
REQ-036 Reset asserted in WAIT_DONE of a locked packet.
- Next cycle: locked=0, ptr=0, IDLE; a pending requester 3 is granted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding and default UART frame width.
package uart_pkg;
   localparam int UART_BITS = 8;
   typedef enum logic [1:0] {IDLE, LOCKED, WAIT_BUSY, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr upward with wrap.
module rr_arbiter #(
   parameter int N = 4,
   localparam int GW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [GW-1:0] ptr,
   output logic [N-1:0]  grant_oh,
   output logic [GW-1:0] grant_idx,
   output logic          any_valid
);
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = |valid;
      // Descending scan so the candidate nearest ptr is written last and wins.
      for (int k = N - 1; k >= 0; k--)
         if (valid[(int'(ptr) + k) % N]) grant_idx = GW'((int'(ptr) + k) % N);
      grant_oh[grant_idx] = any_valid;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of N byte requesters onto one UART
// transmitter, holding the grant across multi-byte packets.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int BITS = UART_BITS,
   parameter int N = 4,
   localparam int GW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [N*BITS-1:0] req_data,
   input  logic [N-1:0]      req_last,
   output logic [N-1:0]      req_ready,
   output logic              tx_start,
   output logic [BITS-1:0]   tx_data,
   input  logic              tx_busy,
   output logic [GW-1:0]     grant_id,
   output logic              locked
);
   arb_state_t state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, arb_idx, win;
   logic [N-1:0] ready_q, ready_d, arb_oh;
   logic [BITS-1:0] data_q, data_d;
   logic locked_q, locked_d, start_q, start_d, any_valid, issue;

   rr_arbiter #(.N(N)) u_rr (
      .valid(req_valid),
      .ptr(ptr_q),
      .grant_oh(arb_oh),
      .grant_idx(arb_idx),
      .any_valid(any_valid)
   );

   always_comb begin
      win      = state_q == LOCKED ? grant_q : arb_idx;
      issue    = state_q == IDLE ? any_valid : state_q == LOCKED && req_valid[grant_q];
      start_d  = issue;
      ready_d  = issue ? (state_q == LOCKED ? N'(1) << grant_q : arb_oh) : '0;
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      locked_d = locked_q;
      data_d   = data_q;
      if (issue) begin
         state_d  = WAIT_BUSY;
         grant_d  = win;
         data_d   = req_data[win*BITS +: BITS];
         locked_d = !req_last[win];
         if (req_last[win]) ptr_d = int'(win) == N - 1 ? '0 : GW'(win + 1'b1);
      end else if (state_q == WAIT_BUSY && tx_busy) begin
         state_d = WAIT_DONE;
      end else if (state_q == WAIT_DONE && !tx_busy) begin
         state_d = locked_q ? LOCKED : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         locked_q <= 1'b0;
         start_q  <= 1'b0;
         ready_q  <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         locked_q <= locked_d;
         start_q  <= start_d;
         ready_q  <= ready_d;
         data_q   <= data_d;
      end
   end

   assign req_ready = ready_q;
   assign tx_start  = start_q;
   assign tx_data   = data_q;
   assign grant_id  = grant_q;
   assign locked    = locked_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester queues and a 16-cycle transmitter drive the arbiter;
// a transaction-level model predicts every output each cycle.
module tb_uart_tx_arbiter;
   localparam int N = 4, BITS = 8, GW = 2, DEPTH = 64;

   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N*BITS-1:0] req_data = '0;
   logic tx_start, tx_busy, locked;
   logic [BITS-1:0] tx_data;
   logic [GW-1:0] grant_id;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.BITS(BITS), .N(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked)
   );

   // Transmitter: busy from the cycle after tx_start, for 16 cycles.
   int busy_cnt = 0;
   always @(posedge clk) busy_cnt <= tx_start ? 16 : (busy_cnt != 0 ? busy_cnt - 1 : 0);
   assign tx_busy = busy_cnt != 0;

   logic [BITS:0] qmem [N][DEPTH];
   int qh [N], qt [N];
   bit en [N];

   // Transaction-level model: ownership, pointer and "transmitter free" flags.
   bit m_free, m_seen;
   int m_ptr, m_owner, m_grant;
   logic [BITS-1:0] m_data;
   int errors = 0, checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int i, input logic [BITS-1:0] d, input bit l);
      if (qt[i] - qh[i] < DEPTH) begin
         qmem[i][qt[i] % DEPTH] = {l, d};
         qt[i]++;
      end
   endtask

   task automatic step();
      logic s_rst, s_b;
      logic [N-1:0] s_v, s_l, e_ready;
      logic [N*BITS-1:0] s_d;
      bit e_start;
      int c;
      s_rst = rst; s_v = req_valid; s_l = req_last; s_d = req_data; s_b = tx_busy;
      @(negedge clk);
      e_start = 0; e_ready = '0; c = -1;
      if (s_rst) begin
         m_free = 1; m_seen = 0; m_ptr = 0; m_owner = -1; m_grant = 0; m_data = '0;
      end else if (m_free) begin
         if (m_owner >= 0) begin
            if (s_v[m_owner]) c = m_owner;
         end else begin
            for (int k = 0; k < N && c < 0; k++)
               if (s_v[(m_ptr + k) % N]) c = (m_ptr + k) % N;
         end
         if (c >= 0) begin
            e_start = 1; e_ready[c] = 1'b1; m_grant = c;
            m_data = s_d[c*BITS +: BITS];
            m_owner = s_l[c] ? -1 : c;
            if (s_l[c]) m_ptr = (c + 1) % N;
            m_free = 0; m_seen = 0;
         end
      end else if (!m_seen) m_seen = s_b;
      else if (!s_b) m_free = 1;
      check("tx_start", 32'(tx_start), 32'(e_start));
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("locked", 32'(locked), 32'(m_owner >= 0));
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] && qh[i] != qt[i]) qh[i]++;
         req_valid[i] = en[i] && qh[i] != qt[i];
         {req_last[i], req_data[i*BITS +: BITS]} = qmem[i][qh[i] % DEPTH];
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_ready(input int i);
      for (int k = 0; k < 100 && !req_ready[i]; k++) step();
      check("wait_ready", 32'(req_ready[i]), 32'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         qh[i] = 0; qt[i] = 0; en[i] = 1;
         for (int j = 0; j < DEPTH; j++) qmem[i][j] = '0;
      end
      run(3);
      rst = 1'b0;
      push(0, 8'h5C, 1);
      run(30);
      push(0, 8'h11, 1); push(1, 8'h22, 1);
      run(60);
      pulse_reset();
      for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1);
      run(100);
      push(2, 8'h31, 0); push(2, 8'h32, 0); push(2, 8'h33, 1);
      run(2);
      for (int j = 0; j < 3; j++) push(1, 8'h40 + 8'(j), 1);
      run(150);
      push(2, 8'h51, 0);
      wait_ready(2);
      en[2] = 0;
      push(2, 8'h52, 1); push(0, 8'h53, 1);
      run(50);
      en[2] = 1;
      run(60);
      push(2, 8'h61, 0); push(2, 8'h62, 1); push(3, 8'h63, 1);
      for (int k = 0; k < 100 && !(locked && tx_busy); k++) step();
      check("lock_busy", 32'(locked && tx_busy), 32'd1);
      en[2] = 0;
      pulse_reset();
      run(60);
      en[2] = 1;
      run(60);
      for (int t = 0; t < 2000; t++) begin
         if ($urandom_range(0, 19) == 0) begin
            int r = $urandom_range(0, N - 1);
            int len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
         end
         if ($urandom_range(0, 29) == 0) begin
            int r = $urandom_range(0, N - 1);
            en[r] = !en[r];
         end
         if ($urandom_range(0, 499) == 0) pulse_reset();
         else step();
      end
      for (int i = 0; i < N; i++) en[i] = 1;
      run(300);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
